// File: rtl/line_arb_pkg.sv
// rtl/line_arb_pkg.sv - shared types and defaults for the line round-robin arbiter
//
// Purpose: FSM state encoding and default sizing shared by line_rr_arbiter and rr_pick.
// Contents:
//   state_t     ST_IDLE / ST_GRANT / ST_GAP, 2-bit encoding
//   N_REQ_DEF   default requester count (power of two)
//   ADDR_W_DEF  default decoder address width, log2(N_REQ_DEF)
package line_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 2;

endpackage

// File: rtl/line_rr_arbiter_rr_pick.sv
// rtl/line_rr_arbiter_rr_pick.sv - combinational round-robin pick for the line arbiter
//
// Purpose: choose the first asserted request at or after the priority pointer, cyclically.
// Method:  rotate req down by ptr, priority-encode the lowest set bit, add ptr back.
// Ports:
//   req    in   N_REQ   request vector
//   ptr    in   ADDR_W  priority pointer (highest-priority index)
//   valid  out  1       any request asserted
//   index  out  ADDR_W  selected requester index
module rr_pick
  import line_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              valid,
  output logic [ADDR_W-1:0] index
);

  logic [N_REQ-1:0]  rot;
  logic [ADDR_W-1:0] off;

  always_comb begin
    rot = '0;
    // N_REQ is a power of two, so ADDR_W-bit index arithmetic wraps for free.
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ADDR_W'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    // Scan downwards so the lowest set bit (closest to the pointer) wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = ADDR_W'(i);
      end
    end
  end

  assign valid = |req;
  assign index = ptr + off;

endmodule

// File: rtl/line_rr_arbiter.sv
// rtl/line_rr_arbiter.sv - round-robin owner of the shared one-hot line decoder
//
// Purpose: grants the decoder to one requester at a time, round-robin, with a one-cycle
//          break-before-make gap between owners. All outputs are registered.
// Optional feature: macro ARB_TIMEOUT_EN bounds a tenure to MAX_HOLD grant cycles.
// Ports:
//   clk      in   1       clock, rising edge
//   rst      in   1       asynchronous active-high reset
//   req      in   N_REQ   level requests, held for the whole transaction
//   grant    out  N_REQ   one-hot grant, zero outside GRANT
//   address  out  ADDR_W  decoder address, index of current/last owner
//   enable   out  1       decoder enable, high only in GRANT
//   busy     out  1       high in GRANT or GAP
//   timeout  out  1       one-cycle pulse in the GAP after a forced release
module line_rr_arbiter
  import line_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [ADDR_W-1:0] address,
  output logic              enable,
  output logic              busy,
  output logic              timeout
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              pick_valid;
  logic [ADDR_W-1:0] pick_idx;
  logic              hold_expired;

  rr_pick #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // hold_cnt is zero in the first grant cycle, so MAX_HOLD-1 marks the last allowed cycle.
  assign hold_expired = (state == ST_GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign timeout      = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Only a release while req is still held counts as forced.
      timeout_q <= hold_expired && req[address];
      if (state == ST_GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_hold_cfg;

  assign unused_hold_cfg = CNT_W'(MAX_HOLD);
  assign hold_expired    = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant   <= '0;
      address <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_GRANT;
            address <= pick_idx;
            grant   <= N_REQ'(1) << pick_idx;
            enable  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_GRANT: begin
          // No preemption: only the owner's own req (or the hold limit) ends the tenure.
          if (!req[address] || hold_expired) begin
            state  <= ST_GAP;
            grant  <= '0;
            enable <= 1'b0;
            ptr    <= address + 1'b1;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          grant  <= '0;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_rr_arbiter.sv
// tb/tb_line_rr_arbiter.sv - self-checking bench for line_rr_arbiter
module tb_line_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] address;
  logic       enable;
  logic       busy;
  logic       timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] exp_q[$];
  logic [1:0] exp_et_q[$];

  line_rr_arbiter #(
    .N_REQ    (4),
    .ADDR_W   (2),
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .address (address),
    .enable  (enable),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Invariant checker, sampled mid-cycle.
  logic       prev_en = 1'b0;
  logic [1:0] prev_addr = 2'd0;

  always @(negedge clk) begin
    if (!rst) begin
      tests_run++;
      if (!$onehot0(grant)) begin
        tests_failed++;
        $display("FAIL onehot0: grant=%b", grant);
      end
      tests_run++;
      if (enable !== (|grant)) begin
        tests_failed++;
        $display("FAIL enable_vs_grant: enable=%b grant=%b", enable, grant);
      end
      if (enable) begin
        tests_run++;
        if (grant !== (4'b0001 << address)) begin
          tests_failed++;
          $display("FAIL grant_vs_address: grant=%b required=%b", grant, 4'b0001 << address);
        end
      end
      if (enable && prev_en) begin
        tests_run++;
        if (address !== prev_addr) begin
          tests_failed++;
          $display("FAIL break_before_make: address=%0d previous=%0d", address, prev_addr);
        end
      end
    end
    prev_en   <= enable && !rst;
    prev_addr <= address;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    req = 4'b0000;
    repeat (3) tick;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL settle_idle: busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset;
    req = 4'b1111;
    #2 rst = 1'b1;
    tick;
    tick;
    tests_run++;
    if ({grant, address, enable, busy, timeout} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b address=%0d enable=%b busy=%b timeout=%b required all 0",
               grant, address, enable, busy, timeout);
    end
    rst = 1'b0;
    tick;
    tests_run++;
    if (grant !== 4'b0001 || enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_grant: grant=%b enable=%b required 0001/1", grant, enable);
    end
    req = 4'b0000;
    tick;
    tests_run++;
    if (enable !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_gap: enable=%b busy=%b required 0/1", enable, busy);
    end
    tick;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single;
    req = 4'b0100;
    tick;
    for (int k = 1; k <= 5; k++) begin
      tests_run++;
      if (enable !== 1'b1 || address !== 2'd2) begin
        tests_failed++;
        $display("FAIL single_hold cycle %0d: enable=%b address=%0d required 1/2", k, enable, address);
      end
      if (k < 5) tick;
    end
    req = 4'b0000;
    tick;
    tests_run++;
    if (enable !== 1'b0 || grant !== 4'b0000 || busy !== 1'b1 || address !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_gap: enable=%b grant=%b busy=%b address=%0d required 0/0000/1/2",
               enable, grant, busy, address);
    end
    tick;
    tests_run++;
    if (busy !== 1'b0 || enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b enable=%b required 0/0", busy, enable);
    end
  endtask

  // Each owner drops its req the cycle after its grant and re-raises it one cycle later.
  // Expected grants are taken from exp_q in order.
  task automatic test_tenures(input string name, input logic [3:0] pattern);
    int         last_t  = -1;
    logic       dropped = 1'b0;
    logic [3:0] exp;
    req = pattern;
    for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
      tick;
      if (dropped) begin
        req     = pattern;
        dropped = 1'b0;
      end
      if (enable) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (grant !== exp) begin
          tests_failed++;
          $display("FAIL %s_grant: grant=%b required=%b", name, grant, exp);
        end
        if (last_t >= 0) begin
          tests_run++;
          if (cyc - last_t != 3) begin
            tests_failed++;
            $display("FAIL %s_spacing: spacing=%0d required=3", name, cyc - last_t);
          end
        end
        last_t  = cyc;
        req     = pattern & ~grant;
        dropped = 1'b1;
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_budget: %0d grants outstanding required 0", name, exp_q.size());
    end
    exp_q.delete();
    settle;
  endtask

  task automatic test_wrap;
    // Pointer is 3 after owner 2 released in test_single.
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    test_tenures("wrap", 4'b1001);
  endtask

  task automatic test_rotation;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    test_tenures("rotation", 4'b1111);
  endtask

  task automatic test_timeout;
    logic [1:0] exp;
    for (int i = 0; i < 40; i++) begin
`ifdef ARB_TIMEOUT_EN
      if ((i % 18) < 16)       exp_et_q.push_back(2'b10);
      else if ((i % 18) == 16) exp_et_q.push_back(2'b01);
      else                     exp_et_q.push_back(2'b00);
`else
      exp_et_q.push_back(2'b10);
`endif
    end
    req = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      tick;
      exp = exp_et_q.pop_front();
      tests_run++;
      if ({enable, timeout} !== exp) begin
        tests_failed++;
        $display("FAIL timeout_cycle %0d: enable,timeout=%b required=%b", i + 1, {enable, timeout}, exp);
      end
      if (enable) begin
        tests_run++;
        if (address !== 2'd1) begin
          tests_failed++;
          $display("FAIL timeout_owner: address=%0d required=1", address);
        end
      end
    end
    exp_et_q.delete();
    settle;
  endtask

  task automatic test_reset_mid_grant;
    req = 4'b0100;
    tick;
    tests_run++;
    if (enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre: enable=%b required 1", enable);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({grant, address, enable, busy, timeout} !== 9'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: grant=%b address=%0d enable=%b busy=%b timeout=%b required all 0",
               grant, address, enable, busy, timeout);
    end
    req = 4'b1111;
    tick;
    rst = 1'b0;
    tick;
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL midrst_pointer: grant=%b required=0001", grant);
    end
    settle;
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_rotation;
    test_timeout;
    test_reset_mid_grant;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
